mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit for the MIPS datapath.
- Executes the R-type funct codes the single-cycle ALU does not handle: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI/LO registers and exposes them continuously for MFHI/MFLO.
- Sits beside the ALU in EX; the control unit issues `start` with the same `func`/`a`/`b` bus and stalls on `busy`.

---
 rtl/mdu_hilo.sv | 162 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// Optional MDU_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_hilo #(
   parameter int unsigned ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  func,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcd_q, mcd_d;
   logic [31:0] mpl_q, mpl_d;
   logic        div_q, div_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        signed_op;
   logic [31:0] a_op, b_op;
   logic [63:0] mul_acc, div_acc, step_acc, fin_acc, prod;
   logic [32:0] rem_diff;
   logic [31:0] quo, rem;
   logic        last;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcd_d   = mcd_q;
      mpl_d   = mpl_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      signed_op = (func == F_MULT) || (func == F_DIV);
      a_op      = (signed_op && a[31]) ? -a : a;
      b_op      = (signed_op && b[31]) ? -b : b;

      // acc holds the product (multiply) or {remainder, dividend->quotient} (divide)
      mul_acc  = acc_q + (mpl_q[0] ? mcd_q : '0);
      rem_diff = acc_q[63:31] - {1'b0, mcd_q[31:0]};
      div_acc  = rem_diff[32] ? {acc_q[62:0], 1'b0} : {rem_diff[31:0], acc_q[30:0], 1'b1};
      step_acc = div_q ? div_acc : mul_acc;
      fin_acc  = step_acc;
      last     = (cnt_q == 6'd1);
`ifdef MDU_EARLY_TERM_EN
      if (!div_q && (mpl_q == '0)) begin
         fin_acc = acc_q;
         last    = 1'b1;
      end
`endif
      prod = neg_q ? -fin_acc : fin_acc;
      quo  = dz_q ? '1 : (neg_q ? -fin_acc[31:0] : fin_acc[31:0]);
      rem  = rneg_q ? -fin_acc[63:32] : fin_acc[63:32];

      case (state_q)
         IDLE: begin
            if (start) begin
               case (func)
                  F_MTHI: hi_d = a;
                  F_MTLO: lo_d = a;
                  F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                     div_d   = func[1];
                     neg_d   = signed_op && (a[31] ^ b[31]);
                     rneg_d  = signed_op && a[31];
                     dz_d    = func[1] && (b == '0);
                     cnt_d   = ITER[5:0];
                     mpl_d   = b_op;
                     state_d = CALC;
                     if (func[1]) begin
                        acc_d = {32'd0, a_op};
                        mcd_d = {32'd0, b_op};
                     end else begin
                        acc_d = '0;
                        mcd_d = {32'd0, a_op};
                     end
                  end
                  default: ;
               endcase
            end
         end
         CALC: begin
            acc_d = step_acc;
            mcd_d = div_q ? mcd_q : {mcd_q[62:0], 1'b0};
            mpl_d = {1'b0, mpl_q[31:1]};
            cnt_d = cnt_q - 6'd1;
            if (last) begin
               state_d = FIN;
               if (div_q) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcd_q   <= '0;
         mpl_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcd_q   <= mcd_d;
         mpl_q   <= mpl_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);
   assign div_by_zero = (state_q == FIN) && dz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and random checks of mdu_hilo against a 64-bit arithmetic reference.
module tb_mdu_hilo;

   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [5:0]  func;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   mdu_hilo #(.ITER(32)) dut (
      .clk(clk), .reset(reset), .start(start), .func(func), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {hi, lo} from plain signed/unsigned 64-bit arithmetic.
   function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, q, r;
      logic [63:0] ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (f)
         F_MULT:  return sx * sy;
         F_MULTU: return ux * uy;
         default: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (f == F_DIV) begin
               q = sx / sy;
               r = sx % sy;
            end else begin
               q = longint'(ux / uy);
               r = longint'(ux % uy);
            end
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Cycles from the negedge after the start edge until done is seen.
   function automatic int exp_lat(input logic [5:0] f, input logic [31:0] y);
`ifdef MDU_EARLY_TERM_EN
      logic [31:0] m;
      int          bits;
      if (f == F_MULT || f == F_MULTU) begin
         m    = (f == F_MULT && y[31]) ? -y : y;
         bits = 0;
         for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
         return (bits == 32) ? 33 : bits + 2;
      end
`endif
      return (f == 6'd0) ? 0 : 33;
   endfunction

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input int inj);
      logic [63:0] r;
      int          n, lat;
      logic        is_dz;
      r     = ref_model(f, x, y);
      lat   = exp_lat(f, y);
      is_dz = (f == F_DIV || f == F_DIVU) && (y == 32'd0);
      @(negedge clk);
      start = 1'b1; func = f; a = x; b = y;
      @(negedge clk);
      start = 1'b0; func = 6'($urandom); a = $urandom; b = $urandom;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         check({tag, " busy"}, 64'(busy), 64'd1);
         check({tag, " dz_early"}, 64'(div_by_zero), 64'd0);
         check({tag, " hi_hold"}, 64'(hi), 64'(m_hi));
         check({tag, " lo_hold"}, 64'(lo), 64'(m_lo));
         if (n == inj) begin
            start = 1'b1; func = F_MULTU; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " busy_fin"}, 64'(busy), 64'd1);
      check({tag, " dz"}, 64'(div_by_zero), 64'(is_dz));
      check({tag, " hi"}, 64'(hi), 64'(r[63:32]));
      check({tag, " lo"}, 64'(lo), 64'(r[31:0]));
      m_hi = r[63:32];
      m_lo = r[31:0];
      @(negedge clk);
      check({tag, " busy_after"}, 64'(busy), 64'd0);
      check({tag, " done_after"}, 64'(done), 64'd0);
      check({tag, " dz_after"}, 64'(div_by_zero), 64'd0);
      check({tag, " hi_after"}, 64'(hi), 64'(m_hi));
      check({tag, " lo_after"}, 64'(lo), 64'(m_lo));
   endtask

   initial begin
      logic [5:0]  rf;
      logic [31:0] rx, ry;
      reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst dz", 64'(div_by_zero), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      reset = 1'b0;

      // MTHI then MTLO on consecutive idle cycles, then an unsupported funct
      @(negedge clk);
      start = 1'b1; func = F_MTHI; a = 32'hDEAD_BEEF;
      @(negedge clk);
      check("mthi hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
      check("mthi lo", 64'(lo), 64'd0);
      check("mthi busy", 64'(busy), 64'd0);
      check("mthi done", 64'(done), 64'd0);
      func = F_MTLO; a = 32'h0BAD_F00D;
      @(negedge clk);
      check("mtlo lo", 64'(lo), 64'h0000_0000_0BAD_F00D);
      check("mtlo hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
      check("mtlo busy", 64'(busy), 64'd0);
      check("mtlo done", 64'(done), 64'd0);
      func = 6'b100000; a = 32'h1111_2222; b = 32'h3333_4444;
      @(negedge clk);
      check("badf busy", 64'(busy), 64'd0);
      check("badf hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
      check("badf lo", 64'(lo), 64'h0000_0000_0BAD_F00D);
      start = 1'b0;
      m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;

      // Asynchronous reset ten cycles into a MULTU
      @(negedge clk);
      start = 1'b1; func = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("midrst busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      check("midrst hi", 64'(hi), 64'd0);
      check("midrst lo", 64'(lo), 64'd0);
      @(negedge clk);
      check("midrst busy_next", 64'(busy), 64'd0);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;

      run_op("multu_3x5", F_MULTU, 32'd3, 32'd5, 0);
      run_op("mult_m2x7", F_MULT, 32'hFFFF_FFFE, 32'd7, 2);
      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mult_minsq", F_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'd2, 10);
      run_op("divu_100d7", F_DIVU, 32'd100, 32'd7, 0);
      run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("divu_dz", F_DIVU, 32'h0000_1234, 32'd0, 0);
      run_op("div_dz_neg", F_DIV, 32'hFFFF_FFFB, 32'd0, 0);
      run_op("div_dz_min", F_DIV, 32'h8000_0000, 32'd0, 0);
      run_op("multu_9x3", F_MULTU, 32'd9, 32'd3, 0);
      run_op("mult_b0", F_MULT, 32'h1234_5678, 32'd0, 0);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       rf = F_MULT;
            1:       rf = F_MULTU;
            2:       rf = F_DIV;
            default: rf = F_DIVU;
         endcase
         rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       ry = 32'd0;
            1:       ry = 32'($urandom_range(1, 255));
            2:       ry = 32'hFFFF_FFFF;
            default: ry = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rf, rx, ry, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
